// File: rtl/spi_reg_bridge_pkg.sv
// spi_reg_bridge_pkg: FSM states, transaction-size encodings and the size helper
// shared by the SPI register bridge.
package spi_reg_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD_WAIT,
        DATA,
        DONE
    } state_t;

    localparam logic [1:0] TXN_8   = 2'b00;
    localparam logic [1:0] TXN_16  = 2'b01;
    localparam logic [1:0] TXN_32  = 2'b10;
    localparam logic [1:0] TXN_RSV = 2'b11;

    // Data-phase width in bits for a txn code; 0 marks the reserved code.
    function automatic logic [7:0] txn_bits(input logic [1:0] txn);
        logic [7:0] n;
        n = 8'd0;
        case (txn)
            TXN_8:   n = 8'd8;
            TXN_16:  n = 8'd16;
            TXN_32:  n = 8'd32;
            TXN_RSV: n = 8'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for one asynchronous SPI pin, with
// registered rise/fall pulses. The level output is aligned with the pulses, so
// a data pin synchronised by another instance is valid when a clock pulse fires.
module spi_sync_edge
    import spi_reg_bridge_pkg::*;
#(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Synchroniser chain, previous-value register and edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~prev;
            fall  <= ~chain[STAGES-1] & prev;
        end
    end

    assign level = prev;

endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave that turns frames of {rw, txn, addr, data}
// into one-cycle write strobes and held read requests on a peripheral bus.
// Optional burst auto-increment is enabled by defining SPI_BRIDGE_BURST_EN.
module spi_reg_bridge
    import spi_reg_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RD_TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic [1:0]        data_write_n,
    output logic [1:0]        data_read_n,
    input  logic [DATA_W-1:0] rdata,
    input  logic              data_ready,
    output logic              busy,
    output logic              err
);

    localparam int unsigned H = 3 + ADDR_W;

    logic unused_cs_level, unused_sclk_level, unused_mosi_rise, unused_mosi_fall;
    logic cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_bit;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk   (clk),
        .rst   (rst),
        .din   (spi_cs_n),
        .level (unused_cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst   (rst),
        .din   (spi_clk),
        .level (unused_sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .rst   (rst),
        .din   (spi_mosi),
        .level (mosi_bit),
        .rise  (unused_mosi_rise),
        .fall  (unused_mosi_fall)
    );

    state_t            state;
    logic [7:0]        cnt;
    logic [7:0]        tmo;
    logic [H-2:0]      hdr;
    logic [DATA_W-1:0] dsh;
    logic              rw;
    logic [1:0]        txn;

    logic [H-1:0]      hdr_next;
    logic [DATA_W-1:0] dsh_next;
    logic [7:0]        n_bits;
    logic [7:0]        hdr_n;

    assign hdr_next = {hdr, mosi_bit};
    assign dsh_next = {dsh[DATA_W-2:0], mosi_bit};
    assign n_bits   = txn_bits(txn);
    assign hdr_n    = txn_bits(hdr_next[ADDR_W+1:ADDR_W]);
    assign busy     = (state != IDLE);

    // Ones in the low n bits; keeps unused upper bytes of a word at zero.
    function automatic logic [DATA_W-1:0] low_mask(input logic [7:0] n);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < int'(DATA_W); i++) m[i] = (i < int'(n));
        return m;
    endfunction

    // Frame FSM with registered bus-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            tmo          <= 8'd0;
            hdr          <= '0;
            dsh          <= '0;
            rw           <= 1'b0;
            txn          <= TXN_8;
            addr         <= '0;
            wdata        <= '0;
            data_write_n <= 2'b11;
            data_read_n  <= 2'b11;
            spi_miso     <= 1'b0;
            err          <= 1'b0;
        end else begin
            data_write_n <= 2'b11;
`ifdef SPI_BRIDGE_BURST_EN
            // Advance the address the cycle after each write strobe.
            if (data_write_n != 2'b11) addr <= addr + ADDR_W'(n_bits >> 3);
`endif
            if (cs_rise) begin
                state       <= IDLE;
                data_read_n <= 2'b11;
                spi_miso    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            cnt      <= 8'd0;
                            err      <= 1'b0;
                            spi_miso <= 1'b0;
                            state    <= HDR;
                        end
                    end
                    HDR: begin
                        if (sclk_rise) begin
                            hdr <= hdr_next[H-2:0];
                            if (cnt == 8'(H - 1)) begin
                                cnt <= 8'd0;
                                if (hdr_n == 8'd0 || hdr_n > 8'(DATA_W)) begin
                                    err   <= 1'b1;
                                    state <= DONE;
                                end else begin
                                    rw   <= hdr_next[H-1];
                                    txn  <= hdr_next[ADDR_W+1:ADDR_W];
                                    addr <= hdr_next[ADDR_W-1:0];
                                    if (hdr_next[H-1]) begin
                                        state <= DATA;
                                    end else begin
                                        data_read_n <= hdr_next[ADDR_W+1:ADDR_W];
                                        tmo         <= 8'd0;
                                        state       <= RD_WAIT;
                                    end
                                end
                            end else begin
                                cnt <= cnt + 8'd1;
                            end
                        end
                    end
                    RD_WAIT: begin
                        // Master clocked data out before the peripheral answered.
                        if (sclk_fall) begin
                            spi_miso <= 1'b0;
                            err      <= 1'b1;
                        end
                        if (data_ready) begin
                            dsh         <= (rdata & low_mask(n_bits)) << (8'(DATA_W) - n_bits);
                            data_read_n <= 2'b11;
                            cnt         <= 8'd0;
                            state       <= DATA;
                        end else if (tmo == 8'(RD_TIMEOUT - 1)) begin
                            data_read_n <= 2'b11;
                            err         <= 1'b1;
                            spi_miso    <= 1'b0;
                            state       <= DONE;
                        end else begin
                            tmo <= tmo + 8'd1;
                        end
                    end
                    DATA: begin
                        if (rw) begin
                            if (sclk_rise) begin
                                dsh <= dsh_next;
                                if (cnt == n_bits - 8'd1) begin
                                    wdata        <= dsh_next & low_mask(n_bits);
                                    data_write_n <= txn;
                                    cnt          <= 8'd0;
`ifdef SPI_BRIDGE_BURST_EN
                                    state        <= DATA;
`else
                                    state        <= DONE;
`endif
                                end else begin
                                    cnt <= cnt + 8'd1;
                                end
                            end
                        end else begin
                            // Word is left-aligned in dsh; MSB leaves on each fall.
                            if (sclk_fall) begin
                                spi_miso <= dsh[DATA_W-1];
                                dsh      <= {dsh[DATA_W-2:0], 1'b0};
                            end
                            if (sclk_rise) begin
                                if (cnt == n_bits - 8'd1) begin
                                    cnt <= 8'd0;
`ifdef SPI_BRIDGE_BURST_EN
                                    addr        <= addr + ADDR_W'(n_bits >> 3);
                                    data_read_n <= txn;
                                    tmo         <= 8'd0;
                                    state       <= RD_WAIT;
`else
                                    state       <= DONE;
`endif
                                end else begin
                                    cnt <= cnt + 8'd1;
                                end
                            end
                        end
                    end
                    DONE: begin
                        spi_miso <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Parametrised SPI-slave to peripheral-register bridge: the next generation of the harness SPI register access block.
- Decodes SPI mode-0 frames into single-cycle write strobes and held read requests with a data_ready handshake.
- Adds configurable address/data width, built-in input synchronisers, a read timeout with sticky error, and optional burst auto-increment.
- Sits between the top-level uio pins and one peripheral's address/data/strobe interface.

Parameters:
- ADDR_W, 6, address bits in frame header and on addr.
- DATA_W, 32, maximum data width; must be 8, 16 or 32.
- SYNC_STAGES, 2, flops in each cs_n/sclk/mosi synchroniser; minimum 2.
- RD_TIMEOUT, 64, clk cycles allowed from read request to data_ready; range 1..255.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- spi_cs_n  in  1  chip select, active low, asynchronous to clk.
- spi_clk  in  1  SPI clock, asynchronous to clk; must be slower than clk/4.
- spi_mosi  in  1  serial data in, asynchronous to clk.
- spi_miso  out  1  serial data out.
- addr  out  ADDR_W  register address.
- wdata  out  DATA_W  write data; bits above the transfer width are 0.
- data_write_n  out  2  write strobe, encoding txn; 11 = idle.
- data_read_n  out  2  read request, encoding txn; 11 = idle.
- rdata  in  DATA_W  read data from the peripheral.
- data_ready  in  1  read data valid, one-cycle pulse.
- busy  out  1  high while a frame is in progress.
- err  out  1  sticky error flag; cleared on the next falling edge of spi_cs_n.

Behaviour:
- Reset values: addr=0, wdata=0, data_write_n=11, data_read_n=11, spi_miso=0, busy=0, err=0, FSM=IDLE.
- Sampling:
  - Edges are detected on the synchronised spi_clk.
  - MOSI is sampled on sclk rising; MISO shifts on sclk falling.
  - All transfers are MSB-first.
- Frame header is H = 3+ADDR_W bits, in order:
  - rw (1 = write);
  - txn[1:0] (00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = reserved);
  - addr.
- The data phase follows the header; its width N is 8, 16 or 32.
- If the frame width exceeds DATA_W, or txn=11: set err, go to DONE, issue no strobe.
- FSM states:
  - IDLE: on cs_n falling, clear bit counter, clear err, go to HDR.
  - HDR: shift header bits. On the H-th rising edge latch rw/txn/addr. Writes go to DATA. Reads assert data_read_n=txn and go to RD_WAIT.
  - RD_WAIT: hold data_read_n. On data_ready, capture rdata with bits >= N zeroed, release data_read_n to 11, go to DATA. After RD_TIMEOUT cycles without data_ready, release data_read_n, set err, go to DONE.
  - DATA, write frames: after the N-th rising edge, present wdata and pulse data_write_n=txn for exactly one clk, then go to DONE.
  - DATA, read frames: shift the captured word out on MISO. If the first data falling edge arrives while still in RD_WAIT, drive MISO=0 and set err.
  - DONE: ignore sclk and drive MISO=0 until cs_n rises, then go to IDLE.
- cs_n rising in any state:
  - immediate return to IDLE;
  - partial write discarded, no strobe issued;
  - pending read request released.
- busy = (state != IDLE).
- Latency: write strobe occurs SYNC_STAGES+2 clk after the last data sclk rising edge at the pin.
- The 2-bit strobe encoding and zero-masking of unused upper bytes match the peripheral bus convention.

Optional Feature:
- Macro: SPI_BRIDGE_BURST_EN.
- Defined: after a completed word, if cs_n stays low, addr += N/8 (wrapping at 2^ADDR_W). The FSM returns to DATA (write) or re-issues the read (RD_WAIT) for the next word, with no new header. Each write word gives its own one-cycle strobe.
- Undefined: after one word the FSM enters DONE; extra clocks are ignored and MISO=0.

Decomposition:
- Package spi_reg_bridge_pkg:
  - state enum (IDLE, HDR, RD_WAIT, DATA, DONE);
  - txn encoding constants TXN_8/TXN_16/TXN_32/TXN_RSV;
  - function txn_bits(txn) returning N.
- Sub-module spi_sync_edge, instantiated for cs_n, sclk and mosi:
  - SYNC_STAGES flop chain;
  - registered previous value;
  - rise/fall pulse outputs.

Test Plan:
- Write 32-bit, addr=0x05, data 0xDEADBEEF -> single-cycle data_write_n=10, addr=0x05, wdata=0xDEADBEEF; busy falls after cs_n rises.
- Read 16-bit, addr=0x12; peripheral returns data_ready 3 cycles later with rdata=0xCAFE1234 -> data_read_n=01 held exactly 3 cycles; MISO shifts 0x1234.
- Read with data_ready never asserted, RD_TIMEOUT=64 -> data_read_n released after 64 cycles, err=1, MISO=0; next cs_n falling clears err.
- Write 8-bit, cs_n raised after 5 data bits -> no strobe, FSM returns to IDLE, wdata unchanged.
- txn=11, or txn=10 with DATA_W=16 -> err=1, no read or write strobe.
- With SPI_BRIDGE_BURST_EN: 8-bit write to addr=0x3F, three bytes 0xA1/0xB2/0xC3 -> three strobes at addr 0x3F/0x00/0x01. Without the macro: one strobe only.
